// File: rtl/gamma_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gamma_pkg
// Description : Shared types and constants for the gamma LUT loader.
//               Holds the loader state encoding, the gamma_bus bit map seen
//               by the video mixer, and the LUT depth (256 each R,G,B).
// Revision    : 1.0 - initial release
// ============================================================================
package gamma_pkg;

    // Loader sequencing states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        WRITE = 2'd2,
        FIN   = 2'd3
    } gamma_state_t;

    // gamma_bus bit map
    localparam int PRESENT = 21;  // mixer reports gamma support (sampled)
    localparam int CLK     = 20;  // write clock for the mixer LUT
    localparam int EN      = 19;  // gamma enable
    localparam int WR      = 18;  // LUT write strobe
    localparam int ADDR_HI = 17;  // LUT address, upper bit
    localparam int ADDR_LO = 8;   // LUT address, lower bit

    localparam int GAMMA_ENTRIES = 768;

endpackage
`default_nettype wire

// File: rtl/sync_bit.sv
`default_nettype none
// ============================================================================
// Module      : sync_bit
// Description : Two-flop synchronizer for a single level signal crossing
//               into the clk domain. Both flops clear on reset_n.
// Ports       : clk     in  destination clock
//               reset_n in  async active-low reset
//               d       in  asynchronous input level
//               q       out synchronized level
// Revision    : 1.0 - initial release
// ============================================================================
module sync_bit (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/gamma_loader.sv
`default_nettype none
// ============================================================================
// Module      : gamma_loader
// Description : Sequences a full gamma LUT load (ENTRIES bytes, ascending
//               address) from a host byte stream onto the mixer gamma_bus.
//               Gamma is forced off for the whole load so a half-written
//               table is never applied; the user enable returns afterwards.
//               Writing starts on a VBlank rising edge.
// Config      : GAMMA_LOADER_VBL_GATE_EN - when defined, beats are accepted
//               only while synced VBlank is high; otherwise, once writing
//               starts, it continues through active video.
// Ports       : clk_sys      in  system clock (also forwarded on gamma_bus)
//               reset_n      in  async active-low reset
//               gamma_bus    io  [21] gamma present in, [20:0] driven out
//               cfg_gamma_en in  user gamma enable
//               start/abort  in  1-cycle load control pulses
//               s_valid/s_data/s_ready  host byte stream handshake
//               vblank_in    in  mixer VBlank (video clock domain)
//               busy         out load in progress
//               done/err     out 1-cycle completion / error pulses
// Revision    : 1.0 - initial release
// ============================================================================
module gamma_loader
    import gamma_pkg::*;
#(
    parameter int ENTRIES = GAMMA_ENTRIES,
    parameter int ADDR_W  = 10
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    inout  wire [21:0] gamma_bus,
    input  logic       cfg_gamma_en,
    input  logic       start,
    input  logic       abort,
    input  logic       s_valid,
    input  logic [7:0] s_data,
    output logic       s_ready,
    input  logic       vblank_in,
    output logic       busy,
    output logic       done,
    output logic       err
);

    gamma_state_t r_state;
    gamma_state_t w_state_nxt;

    logic              w_present;
    logic              w_vbl_s;
    logic              r_vbl_d;
    logic              w_vbl_rise;
    logic              w_gate;
    logic              w_ready;
    logic              w_beat;
    logic              w_last;
    logic              w_err_nxt;

    logic [ADDR_W-1:0] r_addr;
    logic              r_en;
    logic              r_wr;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [7:0]        r_wr_data;
    logic              r_err;

    assign w_present = gamma_bus[PRESENT];

    sync_bit u_vbl_sync (
        .clk     (clk_sys),
        .reset_n (reset_n),
        .d       (vblank_in),
        .q       (w_vbl_s)
    );

    assign w_vbl_rise = w_vbl_s & ~r_vbl_d;

`ifdef GAMMA_LOADER_VBL_GATE_EN
    assign w_gate = w_vbl_s;
`else
    assign w_gate = 1'b1;
`endif

    // No beats are taken once the mixer stops reporting gamma support.
    assign w_ready = (r_state == WRITE) & w_gate & w_present;
    assign w_beat  = s_valid & w_ready;
    assign w_last  = (r_addr == ADDR_W'(ENTRIES - 1));
    assign s_ready = w_ready;
    assign err     = r_err;

    always_comb begin
        w_state_nxt = r_state;
        w_err_nxt   = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                // abort is meaningless here, so start always wins
                if (start) begin
                    if (w_present) w_state_nxt = ARM;
                    else           w_err_nxt   = 1'b1;
                end
            end
            ARM: begin
                busy = 1'b1;
                if (!w_present) begin
                    w_state_nxt = IDLE;
                    w_err_nxt   = 1'b1;
                end else if (abort) begin
                    w_state_nxt = IDLE;
                end else if (w_vbl_rise) begin
                    w_state_nxt = WRITE;
                end
            end
            WRITE: begin
                busy = 1'b1;
                if (!w_present) begin
                    w_state_nxt = IDLE;
                    w_err_nxt   = 1'b1;
                end else if (abort) begin
                    w_state_nxt = IDLE;
                end else if (w_beat && w_last) begin
                    w_state_nxt = FIN;
                end
            end
            FIN: begin
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_vbl_d   <= 1'b0;
            r_addr    <= '0;
            r_en      <= 1'b0;
            r_wr      <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_vbl_d <= w_vbl_s;
            r_err   <= w_err_nxt;

            // Counter is held at zero while armed; the FIN transition on the
            // last beat keeps it from ever wrapping.
            if (r_state == ARM) begin
                r_addr <= '0;
            end else if (w_beat && !w_last) begin
                r_addr <= r_addr + 1'b1;
            end

            // A beat accepted on this edge is presented on the bus for
            // exactly the following cycle, even if the load is cancelled.
            r_wr <= w_beat;
            if (w_beat) begin
                r_wr_addr <= r_addr;
                r_wr_data <= s_data;
            end

            // User enable applies only while the loader rests in IDLE.
            r_en <= (w_state_nxt == IDLE) ? cfg_gamma_en : 1'b0;
        end
    end

    assign gamma_bus[CLK]             = clk_sys;
    assign gamma_bus[EN]              = r_en;
    assign gamma_bus[WR]              = r_wr;
    assign gamma_bus[ADDR_HI:ADDR_LO] = r_wr_addr;
    assign gamma_bus[7:0]             = r_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_gamma_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_gamma_loader
// Description : Self-checking bench for gamma_loader. A reference queue of
//               expected {addr,data} LUT writes is filled as the bench hands
//               beats to the loader and drained by a bus monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gamma_loader;
    import gamma_pkg::*;

`ifdef GAMMA_LOADER_VBL_GATE_EN
    localparam bit GATED = 1'b1;
`else
    localparam bit GATED = 1'b0;
`endif

    logic       clk_sys;
    logic       reset_n;
    logic       cfg_gamma_en;
    logic       start;
    logic       abort;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_ready;
    logic       vblank_in;
    logic       busy;
    logic       done;
    logic       err;
    logic       present;
    wire [21:0] gamma_bus;

    assign gamma_bus[PRESENT] = present;

    gamma_loader dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .gamma_bus    (gamma_bus),
        .cfg_gamma_en (cfg_gamma_en),
        .start        (start),
        .abort        (abort),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_ready      (s_ready),
        .vblank_in    (vblank_in),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    int checks = 0;
    int errors = 0;

    logic [17:0] exp_q[$];
    int          m_addr;
    int          wr_count   = 0;
    int          done_count = 0;
    int          err_count  = 0;
    bit          strict_wr  = 1'b0;
    logic        prev_wr    = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    // Bus monitor: every write strobe must match the next expected entry.
    always @(negedge clk_sys) begin
        if (reset_n) begin
            if (gamma_bus[WR] === 1'b1) begin
                wr_count++;
                if (strict_wr) chk("wr_width", {31'd0, prev_wr}, 32'd0);
                if (exp_q.size() == 0) begin
                    chk("wr_unexpected", {14'd0, gamma_bus[17:0]}, 32'hFFFFFFFF);
                end else begin
                    chk("wr_addr_data", {14'd0, gamma_bus[17:0]}, {14'd0, exp_q.pop_front()});
                end
            end
            if (done === 1'b1) done_count++;
            if (err === 1'b1)  err_count++;
            prev_wr = gamma_bus[WR];
        end else begin
            prev_wr = 1'b0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic wait_ready();
        int n = 0;
        while (s_ready !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        chk("ready_after_vbl", {31'd0, s_ready}, 32'd1);
    endtask

    // Start a load (optionally with a simultaneous abort) and open the
    // write window with a VBlank rising edge.
    task automatic begin_load(input bit with_abort);
        vblank_in = 1'b0;
        repeat (3) step();
        start = 1'b1;
        abort = with_abort;
        step();
        start = 1'b0;
        abort = 1'b0;
        chk("busy_on_start", {31'd0, busy}, 32'd1);
        chk("en_off_loading", {31'd0, gamma_bus[EN]}, 32'd0);
        chk("ready_in_arm", {31'd0, s_ready}, 32'd0);
        m_addr = 0;
        vblank_in = 1'b1;
        wait_ready();
    endtask

    // mode 0: back-to-back, data = addr[7:0]
    // mode 1: s_valid toggles each cycle (1 first), random data
    // mode 2: random s_valid, random data
    task automatic beats(input int n, input int mode, output int cyc);
        int got = 0;
        int en_bad = 0;
        cyc = 0;
        while (got < n && cyc < 4000) begin
            case (mode)
                0:       s_valid = 1'b1;
                1:       s_valid = (cyc % 2 == 0);
                default: s_valid = 1'($urandom_range(0, 1));
            endcase
            s_data = (mode == 0) ? 8'(m_addr) : 8'($urandom);
            if (gamma_bus[EN] !== 1'b0) en_bad++;
            if (s_valid && s_ready === 1'b1) begin
                exp_q.push_back({10'(m_addr), s_data});
                m_addr++;
                got++;
            end
            step();
            cyc++;
        end
        s_valid = 1'b0;
        chk("beats_budget", got, n);
        chk("en_during_load", en_bad, 0);
    endtask

    task automatic finish_load();
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("busy_in_fin", {31'd0, busy}, 32'd0);
        chk("ready_in_fin", {31'd0, s_ready}, 32'd0);
        step();
        chk("done_width", {31'd0, done}, 32'd0);
        step();
        chk("en_restored", {31'd0, gamma_bus[EN]}, {31'd0, cfg_gamma_en});
        chk("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        int cyc;
        int wr0;
        int done0;

        reset_n = 1'b0; present = 1'b1; cfg_gamma_en = 1'b1;
        start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = 8'd0; vblank_in = 1'b0;

        // Reset values
        step();
        step();
        chk("rst_bus", {12'd0, gamma_bus[19:0]}, 32'd0);
        chk("rst_ready", {31'd0, s_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("bus_clk", {31'd0, gamma_bus[CLK]}, 32'd1);
        reset_n = 1'b1;
        step();
        step();
        chk("idle_en", {31'd0, gamma_bus[EN]}, 32'd1);

        // 1: full back-to-back load; a stray start mid-load is ignored
        wr0 = wr_count;
        begin_load(1'b0);
        beats(200, 0, cyc);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_ignored_busy", {31'd0, busy}, 32'd1);
        beats(568, 0, cyc);
        finish_load();
        chk("t1_wr_count", wr_count - wr0, 768);
        chk("t1_done_count", done_count, 1);

        // 2: start without gamma present
        present = 1'b0;
        wr0 = wr_count;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t2_err", {31'd0, err}, 32'd1);
        chk("t2_busy", {31'd0, busy}, 32'd0);
        step();
        chk("t2_err_width", {31'd0, err}, 32'd0);
        chk("t2_no_wr", wr_count - wr0, 0);
        present = 1'b1;

        // 3: blank falls after 100 beats
        wr0 = wr_count;
        begin_load(1'b0);
        beats(100, 2, cyc);
        vblank_in = 1'b0;
        repeat (3) step();
        chk("t3_ready_after_fall", {31'd0, s_ready}, GATED ? 32'd0 : 32'd1);
        vblank_in = 1'b1;
        wait_ready();
        beats(668, 2, cyc);
        finish_load();
        chk("t3_wr_count", wr_count - wr0, 768);

        // 4: abort after beat 301
        done0 = done_count;
        begin_load(1'b0);
        beats(301, 2, cyc);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t4_busy", {31'd0, busy}, 32'd0);
        chk("t4_ready", {31'd0, s_ready}, 32'd0);
        step();
        step();
        chk("t4_en_cfg", {31'd0, gamma_bus[EN]}, 32'd1);
        chk("t4_no_done", done_count - done0, 0);
        chk("t4_queue", exp_q.size(), 0);

        // abort in IDLE is ignored
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("idle_abort_busy", {31'd0, busy}, 32'd0);

        // 5: start & abort together (start wins), reload from 0, toggling valid
        wr0 = wr_count;
        begin_load(1'b1);
        strict_wr = 1'b1;
        beats(384, 1, cyc);
        chk("t5_cycles", cyc, 767);
        step();
        step();
        strict_wr = 1'b0;
        chk("t5_wr_count", wr_count - wr0, 384);
        beats(384, 2, cyc);
        finish_load();

        // 6: reset mid-load, then a normal load
        cfg_gamma_en = 1'b0;
        begin_load(1'b0);
        beats(500, 2, cyc);
        step();
        step();
        reset_n = 1'b0;
        #1;
        chk("t6_rst_bus", {12'd0, gamma_bus[19:0]}, 32'd0);
        chk("t6_rst_busy", {31'd0, busy}, 32'd0);
        chk("t6_rst_ready", {31'd0, s_ready}, 32'd0);
        chk("t6_rst_done_err", {30'd0, done, err}, 32'd0);
        step();
        reset_n = 1'b1;
        step();
        wr0 = wr_count;
        begin_load(1'b0);
        beats(768, 2, cyc);
        finish_load();
        chk("t6_wr_count", wr_count - wr0, 768);

        // 7: gamma present lost mid-load
        cfg_gamma_en = 1'b1;
        begin_load(1'b0);
        beats(10, 0, cyc);
        present = 1'b0;
        step();
        chk("t7_err", {31'd0, err}, 32'd1);
        chk("t7_busy", {31'd0, busy}, 32'd0);
        present = 1'b1;
        step();
        step();
        chk("t7_en_cfg", {31'd0, gamma_bus[EN]}, 32'd1);

        chk("total_done", done_count, 4);
        chk("total_err", err_count, 2);
        chk("final_queue", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
